operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Read-operand stage directly downstream of the 32x32 register file; it consumes Read_Data_1/2.
//  Fixes the read-during-write hazard with a write-through bypass. The register file writes on
//  the clock edge, so a same-cycle read returns the old value.
//  Registers the operands into a 2-entry valid/ready skid buffer feeding the execute stage.
//  Keeps held operands coherent with writebacks that occur while the entry is stalled.
// PARAMETERS
//  N              32  operand/data width, matches register file width
//  ZERO_REG_HARD   1  1: address 0 reads as 0 and is never bypassed; 0: x0 is an ordinary register
// PORTS
//  clk                 in   1   single clock, rising edge
//  reset               in   1   asynchronous, active-low reset
//  in_valid_i          in   1   decode presents a valid operand request
//  in_ready_o          out  1   stage can accept a request this cycle
//  Read_Register_1_i   in   5   rs1 address (same value driven to register file)
//  Read_Register_2_i   in   5   rs2 address
//  Read_Data_1_i       in   N   register file Read_Data_1_o
//  Read_Data_2_i       in   N   register file Read_Data_2_o
//  Reg_Write_i         in   1   writeback snoop: write enable (same signal as register file)
//  Write_Register_i    in   5   writeback snoop: destination address
//  Write_Data_i        in   N   writeback snoop: data
//  flush_i             in   1   synchronous kill of all buffered entries
//  out_valid_o         out  1   operands valid toward execute
//  out_ready_i         in   1   execute accepts operands
//  Operand_1_o         out  N   bypassed rs1 value
//  Operand_2_o         out  N   bypassed rs2 value
//  Rs1_o / Rs2_o       out  5   addresses of the presented entry
// BEHAVIOUR
//  - Reset (reset=0, async): both entries invalid, out_valid_o=0, Operand_*_o=0, Rs*_o=0,
//    in_ready_o=1.
//  - Handshake: accept when in_valid_i & in_ready_o; transfer out when out_valid_o & out_ready_i.
//    in_ready_o = !skid_valid (registered state, no combinational path from out_ready_i).
//  - Capture mux per source: if ZERO_REG_HARD & rs==0 -> 0; else if Reg_Write_i & Write_Register_i==rs
//    -> Write_Data_i; else Read_Data_x_i. The same write may hit rs1 and rs2 together.
//  - Latency: accepted request appears on out_valid_o next cycle. Throughput is 1 per cycle when
//    out_ready_i=1.
//  - Entry placement, each edge, in priority order:
//    (1) if the out entry transfers or is empty and the skid is valid, the skid moves to out;
//    (2) an accepted input loads out if out will be empty, else loads skid.
//    The skid is never loaded while it is valid.
//  - Held-entry refresh: every cycle, each valid entry (out and skid) whose rs matches an active
//    write (honouring ZERO_REG_HARD) replaces that operand with Write_Data_i. This applies also
//    in the cycle the entry moves skid->out.
//  - Flush: flush_i=1 invalidates both entries at the edge; an input accepted that cycle is
//    dropped. Next cycle out_valid_o=0 and in_ready_o=1. flush_i has priority over all moves.
//  - out_valid_o=0 implies Operand_*_o hold last value (don't care for consumers).
//  - Reset asserted mid-stall: all state cleared immediately; no entry survives.
// STRUCTURE
//  - Shared package: REG_ADDR_W=5, ZERO_REG=5'd0, and the bypass-match function
//    (addr, we, waddr, zero_hard).
//  - Sub-module operand_entry: one valid+rs1/rs2+operand register with load and refresh ports.
//    Instantiated twice (out, skid). The top holds the placement/flush control.
// TESTING
//  1. Reset low mid-traffic -> next sample: out_valid_o=0, in_ready_o=1, Operand_1_o=0.
//  2. rs1=5, RF returns 0x11, same cycle Reg_Write_i=1 Write_Register_i=5 Write_Data_i=0xAB
//     -> Operand_1_o=0xAB next cycle.
//  3. Accept rs2=7 with out_ready_i=0 for 3 cycles; in cycle 2 write r7=0x55
//     -> Operand_2_o=0x55 when released.
//  4. out_ready_i=0, send 2 requests -> in_ready_o=0 after 2nd. Raise out_ready_i ->
//     both emerge in order on consecutive cycles with no loss.
//  5. ZERO_REG_HARD=1, rs1=0, write r0=0xFF same cycle -> Operand_1_o=0.
//  6. Two entries buffered, flush_i=1 with in_valid_i=1 -> out_valid_o=0 next cycle,
//     in_ready_o=1, no entry emitted.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage: register address width,
// the hard-zero register index and the writeback bypass match.
package operand_fetch_stage_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // A write hits an operand address unless it targets a hardwired x0.
    function automatic logic bypass_hit(
        input logic [REG_ADDR_W-1:0] addr,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] waddr,
        input logic                  zero_hard
    );
        return we && (waddr == addr) && !(zero_hard && (addr == ZERO_REG));
    endfunction

endpackage

// File: rtl/operand_fetch_stage_entry.sv
// One buffered operand entry: valid flag, rs1/rs2 addresses and two operands,
// with a load port and continuous writeback refresh while the entry is valid.
module operand_entry
    import operand_fetch_stage_pkg::*;
#(
    parameter int N             = 32,
    parameter bit ZERO_REG_HARD = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_next,
    input  logic                       load,
    input  logic [1:0][REG_ADDR_W-1:0] load_rs,
    input  logic [1:0][N-1:0]          load_op,
    input  logic                       we,
    input  logic [REG_ADDR_W-1:0]      waddr,
    input  logic [N-1:0]               wdata,
    output logic                       valid,
    output logic [1:0][REG_ADDR_W-1:0] rs,
    output logic [1:0][N-1:0]          op,
    output logic [1:0][N-1:0]          fresh_op
);

    logic valid_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    assign valid = valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [REG_ADDR_W-1:0] rs_reg;
            logic [N-1:0]          op_reg;
            logic                  hit;

            // fresh_op is what this slot holds after this cycle's writeback,
            // so a skid->out move carries the refreshed value.
            assign hit          = valid_reg && bypass_hit(rs_reg, we, waddr, ZERO_REG_HARD);
            assign fresh_op[gi] = hit ? wdata : op_reg;
            assign rs[gi]       = rs_reg;
            assign op[gi]       = op_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rs_reg <= '0;
                    op_reg <= '0;
                end else if (load) begin
                    rs_reg <= load_rs[gi];
                    op_reg <= load_op[gi];
                end else begin
                    op_reg <= fresh_op[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: write-through bypass on register file reads, feeding a
// 2-entry skid buffer whose held operands track later writebacks.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int N             = 32,
    parameter bit ZERO_REG_HARD = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [REG_ADDR_W-1:0] Read_Register_1_i,
    input  logic [REG_ADDR_W-1:0] Read_Register_2_i,
    input  logic [N-1:0]          Read_Data_1_i,
    input  logic [N-1:0]          Read_Data_2_i,
    input  logic                  Reg_Write_i,
    input  logic [REG_ADDR_W-1:0] Write_Register_i,
    input  logic [N-1:0]          Write_Data_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [N-1:0]          Operand_1_o,
    output logic [N-1:0]          Operand_2_o,
    output logic [REG_ADDR_W-1:0] Rs1_o,
    output logic [REG_ADDR_W-1:0] Rs2_o
);

    logic [1:0][REG_ADDR_W-1:0] req_rs;
    logic [1:0][N-1:0]          req_rd;
    logic [1:0][N-1:0]          cap_op;

    assign req_rs[0] = Read_Register_1_i;
    assign req_rs[1] = Read_Register_2_i;
    assign req_rd[0] = Read_Data_1_i;
    assign req_rd[1] = Read_Data_2_i;

    // The register file writes on this same edge, so its read data is stale
    // whenever the writeback targets the address being read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_capture
            assign cap_op[gi] =
                (ZERO_REG_HARD && (req_rs[gi] == ZERO_REG)) ? '0 :
                bypass_hit(req_rs[gi], Reg_Write_i, Write_Register_i, ZERO_REG_HARD) ? Write_Data_i :
                req_rd[gi];
        end
    endgenerate

    logic                       out_valid;
    logic                       skid_valid;
    logic [1:0][REG_ADDR_W-1:0] out_rs;
    logic [1:0][REG_ADDR_W-1:0] skid_rs;
    logic [1:0][N-1:0]          out_op;
    logic [1:0][N-1:0]          skid_op;
    logic [1:0][N-1:0]          out_fresh;
    logic [1:0][N-1:0]          skid_fresh;

    logic accept;
    logic out_fire;
    logic out_free;
    logic skid_to_out;
    logic in_to_out;
    logic in_to_skid;
    logic out_valid_next;
    logic skid_valid_next;
    logic out_load;
    logic skid_load;
    logic [1:0][REG_ADDR_W-1:0] out_load_rs;
    logic [1:0][N-1:0]          out_load_op;

    assign in_ready_o  = !skid_valid;
    assign accept      = in_valid_i && in_ready_o;
    assign out_fire    = out_valid && out_ready_i;
    assign out_free    = !out_valid || out_fire;
    assign skid_to_out = out_free && skid_valid;
    assign in_to_out   = accept && out_free && !skid_valid;
    assign in_to_skid  = accept && !(out_free && !skid_valid);

    // Flush overrides every move; any request accepted in that cycle is lost.
    assign out_valid_next  = !flush_i && (skid_to_out || in_to_out || (out_valid && !out_fire));
    assign skid_valid_next = !flush_i && (in_to_skid || (skid_valid && !skid_to_out));
    assign out_load        = !flush_i && (skid_to_out || in_to_out);
    assign skid_load       = !flush_i && in_to_skid;
    assign out_load_rs     = skid_to_out ? skid_rs    : req_rs;
    assign out_load_op     = skid_to_out ? skid_fresh : cap_op;

    operand_entry #(
        .N             (N),
        .ZERO_REG_HARD (ZERO_REG_HARD)
    ) u_out (
        .clk        (clk),
        .reset      (reset),
        .valid_next (out_valid_next),
        .load       (out_load),
        .load_rs    (out_load_rs),
        .load_op    (out_load_op),
        .we         (Reg_Write_i),
        .waddr      (Write_Register_i),
        .wdata      (Write_Data_i),
        .valid      (out_valid),
        .rs         (out_rs),
        .op         (out_op),
        .fresh_op   (out_fresh)
    );

    operand_entry #(
        .N             (N),
        .ZERO_REG_HARD (ZERO_REG_HARD)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .valid_next (skid_valid_next),
        .load       (skid_load),
        .load_rs    (req_rs),
        .load_op    (cap_op),
        .we         (Reg_Write_i),
        .waddr      (Write_Register_i),
        .wdata      (Write_Data_i),
        .valid      (skid_valid),
        .rs         (skid_rs),
        .op         (skid_op),
        .fresh_op   (skid_fresh)
    );

    assign out_valid_o = out_valid;
    assign Operand_1_o = out_op[0];
    assign Operand_2_o = out_op[1];
    assign Rs1_o       = out_rs[0];
    assign Rs2_o       = out_rs[1];

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: bypass, stall refresh, skid ordering,
// hard zero register, flush and asynchronous reset.
module tb_operand_fetch_stage;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [4:0]    Read_Register_1_i;
    logic [4:0]    Read_Register_2_i;
    logic [N-1:0]  Read_Data_1_i;
    logic [N-1:0]  Read_Data_2_i;
    logic          Reg_Write_i;
    logic [4:0]    Write_Register_i;
    logic [N-1:0]  Write_Data_i;
    logic          flush_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [N-1:0]  Operand_1_o;
    logic [N-1:0]  Operand_2_o;
    logic [4:0]    Rs1_o;
    logic [4:0]    Rs2_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_fetch_stage #(.N(N), .ZERO_REG_HARD(1'b1)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .Read_Register_1_i (Read_Register_1_i),
        .Read_Register_2_i (Read_Register_2_i),
        .Read_Data_1_i     (Read_Data_1_i),
        .Read_Data_2_i     (Read_Data_2_i),
        .Reg_Write_i       (Reg_Write_i),
        .Write_Register_i  (Write_Register_i),
        .Write_Data_i      (Write_Data_i),
        .flush_i           (flush_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .Operand_1_o       (Operand_1_o),
        .Operand_2_o       (Operand_2_o),
        .Rs1_o             (Rs1_o),
        .Rs2_o             (Rs2_o)
    );

    task automatic check(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
        $display("check %-24s observed %h expected %h", tag, observed, expected);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] r1, input logic [N-1:0] d1,
                       input logic [4:0] r2, input logic [N-1:0] d2);
        in_valid_i        = 1'b1;
        Read_Register_1_i = r1;
        Read_Data_1_i     = d1;
        Read_Register_2_i = r2;
        Read_Data_2_i     = d2;
    endtask

    task automatic wr(input logic we, input logic [4:0] a, input logic [N-1:0] d);
        Reg_Write_i      = we;
        Write_Register_i = a;
        Write_Data_i     = d;
    endtask

    initial begin
        reset = 1'b0;
        in_valid_i = 1'b0;
        Read_Register_1_i = '0; Read_Register_2_i = '0;
        Read_Data_1_i = '0; Read_Data_2_i = '0;
        wr(1'b0, 5'd0, '0);
        flush_i = 1'b0;
        out_ready_i = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_in_ready",  32'(in_ready_o),  32'd1);
        check("rst_op1",       Operand_1_o,      32'h0);
        check("rst_op2",       Operand_2_o,      32'h0);
        check("rst_rs1",       32'(Rs1_o),       32'd0);
        step();
        reset = 1'b1;
        step();

        // Same-cycle write to rs1 bypasses stale register file data
        req(5'd5, 32'h11, 5'd3, 32'h22);
        wr(1'b1, 5'd5, 32'hAB);
        step();
        in_valid_i = 1'b0; wr(1'b0, 5'd0, '0);
        check("byp_valid", 32'(out_valid_o), 32'd1);
        check("byp_op1",   Operand_1_o,      32'hAB);
        check("byp_op2",   Operand_2_o,      32'h22);
        check("byp_rs1",   32'(Rs1_o),       32'd5);
        step();
        check("byp_drain", 32'(out_valid_o), 32'd0);

        // Hard x0: a write to r0 is not forwarded, and x0 reads as zero
        req(5'd0, 32'h77, 5'd4, 32'h44);
        wr(1'b1, 5'd0, 32'hFF);
        step();
        in_valid_i = 1'b0; wr(1'b0, 5'd0, '0);
        check("zero_op1", Operand_1_o, 32'h0);
        check("zero_op2", Operand_2_o, 32'h44);

        // One write hits rs1 and rs2 together
        req(5'd9, 32'h1, 5'd9, 32'h2);
        wr(1'b1, 5'd9, 32'h99);
        step();
        in_valid_i = 1'b0; wr(1'b0, 5'd0, '0);
        check("dual_op1", Operand_1_o, 32'h99);
        check("dual_op2", Operand_2_o, 32'h99);
        step();

        // Stalled entry picks up a later write to its rs2
        out_ready_i = 1'b0;
        req(5'd1, 32'h10, 5'd7, 32'h70);
        step();
        in_valid_i = 1'b0;
        check("stall_op2_init", Operand_2_o, 32'h70);
        wr(1'b1, 5'd7, 32'h55);
        step();
        wr(1'b0, 5'd0, '0);
        check("stall_op2_refresh", Operand_2_o, 32'h55);
        check("stall_op1_keep",    Operand_1_o, 32'h10);
        step();
        out_ready_i = 1'b1;
        check("stall_valid",   32'(out_valid_o), 32'd1);
        check("stall_release", Operand_2_o,      32'h55);
        step();
        check("stall_drain", 32'(out_valid_o), 32'd0);

        // Two requests fill out and skid; skid refreshes, including on its move
        out_ready_i = 1'b0;
        req(5'd2, 32'hA1, 5'd3, 32'hA2);
        step();
        check("skid_a_ready", 32'(in_ready_o), 32'd1);
        check("skid_a_op1",   Operand_1_o,     32'hA1);
        req(5'd4, 32'hB1, 5'd5, 32'hB2);
        step();
        in_valid_i = 1'b0;
        check("skid_full_ready", 32'(in_ready_o), 32'd0);
        check("skid_hold_op1",   Operand_1_o,     32'hA1);
        wr(1'b1, 5'd4, 32'hC4);
        step();
        check("skid_still_full", 32'(in_ready_o), 32'd0);
        check("skid_out_is_a",   32'(Rs1_o),      32'd2);
        out_ready_i = 1'b1;
        wr(1'b1, 5'd5, 32'hD5);
        step();
        wr(1'b0, 5'd0, '0);
        check("skid_b_valid", 32'(out_valid_o), 32'd1);
        check("skid_b_rs1",   32'(Rs1_o),       32'd4);
        check("skid_b_op1",   Operand_1_o,      32'hC4);
        check("skid_b_op2",   Operand_2_o,      32'hD5);
        check("skid_b_ready", 32'(in_ready_o),  32'd1);
        step();
        check("skid_drain", 32'(out_valid_o), 32'd0);

        // Back-to-back throughput with out_ready held high
        for (int i = 0; i < 3; i++) begin
            req(5'(10 + i), 32'(32'h100 + i), 5'd6, 32'h66);
            step();
            check("tput_valid", 32'(out_valid_o), 32'd1);
            check("tput_op1",   Operand_1_o,      32'(32'h100 + i));
        end
        in_valid_i = 1'b0;
        step();

        // Flush with both entries buffered and a request offered
        out_ready_i = 1'b0;
        req(5'd1, 32'h1, 5'd2, 32'h2);
        step();
        req(5'd3, 32'h3, 5'd4, 32'h4);
        step();
        req(5'd5, 32'h5, 5'd6, 32'h6);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check("flush_valid", 32'(out_valid_o), 32'd0);
        check("flush_ready", 32'(in_ready_o),  32'd1);
        out_ready_i = 1'b1;
        step();
        check("flush_no_emit", 32'(out_valid_o), 32'd0);

        // Flush drops a request accepted in the same cycle
        out_ready_i = 1'b0;
        req(5'd8, 32'h8, 5'd9, 32'h9);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check("flush_drop", 32'(out_valid_o), 32'd0);

        // Asynchronous reset while stalled with a full buffer
        req(5'd11, 32'hEE, 5'd12, 32'hDD);
        step();
        req(5'd13, 32'hCC, 5'd14, 32'hBB);
        step();
        in_valid_i = 1'b0;
        check("pre_rst_valid", 32'(out_valid_o), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid_o), 32'd0);
        check("async_rst_ready", 32'(in_ready_o),  32'd1);
        check("async_rst_op1",   Operand_1_o,      32'h0);
        step();
        reset = 1'b1;
        out_ready_i = 1'b1;
        step();
        check("post_rst_empty", 32'(out_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
